// File: rtl/clk_mode_pkg.sv
// -----------------------------------------------------------------------------
// clk_mode_pkg
//   Shared definitions for the programmable clock-divider controller:
//   the controller FSM state encoding, the smallest legal divide ratio and
//   the default divide-ratio/counter width.
// -----------------------------------------------------------------------------
package clk_mode_pkg;

  // Default width of the divide ratio and of the period counter.
  localparam int CNT_W_DEF = 8;

  // Smallest divide ratio that produces a real clock.
  // Ratios 0 and 1 are rejected.
  localparam int MIN_DIV = 2;

  // Controller states.
  //   ST_OFF       : divided clock parked low, ratio may be loaded directly
  //   ST_RUN       : divided clock running at cur_div
  //   ST_PEND      : new ratio captured, waiting for the current period to end
  //   ST_STOP_PEND : stop requested, waiting for the current period to end
  typedef enum logic [1:0] {
    ST_OFF       = 2'd0,
    ST_RUN       = 2'd1,
    ST_PEND      = 2'd2,
    ST_STOP_PEND = 2'd3
  } state_e;

endpackage : clk_mode_pkg

// File: rtl/clk_div_core.sv
// -----------------------------------------------------------------------------
// clk_div_core
//   Period counter and phase flops of the divided clock.
//
//   While run is high the counter steps 0..div-1 and wraps; while run is low
//   it is held at 0.  pos_clk is high for the first ceil(div/2) counts of
//   each period.  With CLK_MODE_CTRL_ODD50_EN defined, a negedge flop delays
//   pos_clk by half a clock and, for odd div, is ANDed in so the high phase
//   shrinks by half a cycle (50 % duty).  Without the macro clk_out is
//   pos_clk directly.
//
//   div may only change on the edge that wraps the counter (or while run is
//   low), so every high phase completes before a new ratio takes effect.
//
// Ports
//   clk     : input  clock (posedge; negedge too with the ODD50 macro)
//   rst     : input  asynchronous active-high reset
//   run     : input  1 = count and generate, 0 = hold counter and clock low
//   div     : input  [CNT_W-1:0] divide ratio currently in effect
//   last    : output counter is at div-1 (period boundary on the next edge)
//   clk_out : output divided clock
//
// Configuration macro: CLK_MODE_CTRL_ODD50_EN
// -----------------------------------------------------------------------------
module clk_div_core #(
  parameter int CNT_W = clk_mode_pkg::CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [CNT_W-1:0] div,
  output logic             last,
  output logic             clk_out
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   half;
  logic             pos_clk;

  // One extra bit so that div = 2^CNT_W-1 does not overflow when rounding up.
  assign half = ({1'b0, div} + (CNT_W+1)'(1)) >> 1;

  // ">=" rather than "==" so a counter that ever ends up past the boundary
  // still wraps instead of running all the way round.
  assign last = (cnt >= (div - CNT_W'(1)));

  // NOTE: clocked state is written with non-blocking assignments so every
  // flop samples the values from before the edge, regardless of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      pos_clk <= 1'b0;
    end else if (!run) begin
      cnt     <= '0;
      pos_clk <= 1'b0;
    end else begin
      cnt     <= last ? '0 : (cnt + CNT_W'(1));
      pos_clk <= ({1'b0, cnt} < half);
    end
  end

`ifdef CLK_MODE_CTRL_ODD50_EN
  logic neg_clk;

  // Half-cycle delayed copy of pos_clk.  For even ratios the plain pos_clk
  // is already 50 %, so the delayed term is masked to 1.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) neg_clk <= 1'b0;
    else     neg_clk <= pos_clk;
  end

  assign clk_out = pos_clk & (div[0] ? neg_clk : 1'b1);
`else
  assign clk_out = pos_clk;
`endif

endmodule : clk_div_core

// File: rtl/clk_mode_ctrl.sv
// -----------------------------------------------------------------------------
// clk_mode_ctrl
//   Run/stop and ratio-switch controller for a programmable clock divider.
//
//   A new divide ratio is offered with a valid/ready handshake.  In OFF it
//   is loaded at once; in RUN it is parked in a pending register and only
//   loaded on the edge that ends the current period, so clk_out never shows
//   a truncated high phase.  Stopping (en falling) likewise lets the current
//   period finish before the clock parks low.  Ratios below MIN_DIV are
//   accepted but ignored and flagged with a one-cycle err pulse.
//
// Ports
//   clk       : input  clock
//   rst       : input  asynchronous active-high reset
//   en        : input  1 = run the divided clock, 0 = stop it
//   req_valid : input  a new divide ratio is offered
//   req_div   : input  [CNT_W-1:0] requested divide ratio
//   req_ready : output the offered ratio is taken this cycle
//   clk_out   : output divided clock
//   cur_div   : output [CNT_W-1:0] divide ratio currently in effect
//   busy      : output a ratio switch or a stop is waiting for a period end
//   err       : output one-cycle pulse after an illegal ratio was accepted
//
// Parameters
//   CNT_W   : width of the divide ratio and the period counter
//   DIV_RST : divide ratio after reset (2 .. 2^CNT_W-1)
//
// Configuration macro: CLK_MODE_CTRL_ODD50_EN (50 % duty for odd ratios,
// see clk_div_core).
// -----------------------------------------------------------------------------
module clk_mode_ctrl #(
  parameter int CNT_W   = clk_mode_pkg::CNT_W_DEF,
  parameter int DIV_RST = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             req_valid,
  input  logic [CNT_W-1:0] req_div,
  output logic             req_ready,
  output logic             clk_out,
  output logic [CNT_W-1:0] cur_div,
  output logic             busy,
  output logic             err
);

  import clk_mode_pkg::*;

  state_e           state;
  state_e           state_nxt;
  logic [CNT_W-1:0] pend_div;
  logic             last;
  logic             run;
  logic             hs;
  logic             hs_illegal;
  logic             hs_legal;

  // ---------------------------------------------------------------------------
  // Handshake
  //   Ready in OFF, and in RUN while en stays high; a stop request in RUN
  //   closes the port in the same cycle so a ratio cannot sneak in behind it.
  // ---------------------------------------------------------------------------
  assign req_ready  = (state == ST_OFF) || ((state == ST_RUN) && en);
  assign hs         = req_valid && req_ready;
  assign hs_illegal = hs && (req_div < CNT_W'(MIN_DIV));
  assign hs_legal   = hs && !hs_illegal;

  assign busy = (state == ST_PEND) || (state == ST_STOP_PEND);
  assign run  = (state != ST_OFF);

  // ---------------------------------------------------------------------------
  // Next-state logic
  //   A stop arriving during PEND is not acted on until the switch completes:
  //   PEND always returns to RUN, and RUN then sees en low on the next cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: the default assignment up front keeps every path of this block
    // assigning state_nxt, so no latch is inferred.
    state_nxt = state;
    case (state)
      ST_OFF: begin
        if (en) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!en)           state_nxt = ST_STOP_PEND;
        else if (hs_legal) state_nxt = ST_PEND;
      end
      ST_PEND: begin
        if (last) state_nxt = ST_RUN;
      end
      ST_STOP_PEND: begin
        if (last) state_nxt = ST_OFF;
      end
      default: state_nxt = ST_OFF;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, ratio registers and error pulse
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_OFF;
      cur_div  <= CNT_W'(DIV_RST);
      pend_div <= CNT_W'(DIV_RST);
      err      <= 1'b0;
    end else begin
      state <= state_nxt;
      err   <= hs_illegal;

      if (hs_legal) begin
        pend_div <= req_div;
        // Nothing is being generated in OFF, so the ratio can switch at once.
        if (state == ST_OFF) cur_div <= req_div;
      end

      // Period boundary: the counter wraps to 0 on this same edge, so the
      // next period starts cleanly at the new ratio.
      if ((state == ST_PEND) && last) cur_div <= pend_div;
    end
  end

  // ---------------------------------------------------------------------------
  // Counter, phase flops and output gate
  // ---------------------------------------------------------------------------
  clk_div_core #(
    .CNT_W (CNT_W)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .div     (cur_div),
    .last    (last),
    .clk_out (clk_out)
  );

endmodule : clk_mode_ctrl

// File: tb/tb_clk_mode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clk_mode_ctrl
//   Directed bench for clk_mode_ctrl with CNT_W=8, DIV_RST=2.  Inputs are
//   driven 1 time unit after a clock edge; outputs are sampled 1 time unit
//   after an edge.  Edge numbers in comments (E0, E1, ...) count posedges
//   from the first one that samples en high.
// -----------------------------------------------------------------------------
module tb_clk_mode_ctrl;

  import clk_mode_pkg::*;

  localparam int CNT_W = 8;

  logic             clk;
  logic             rst;
  logic             en;
  logic             req_valid;
  logic [CNT_W-1:0] req_div;
  logic             req_ready;
  logic             clk_out;
  logic [CNT_W-1:0] cur_div;
  logic             busy;
  logic             err;

  int total = 0;
  int bad   = 0;

  clk_mode_ctrl #(
    .CNT_W   (CNT_W),
    .DIV_RST (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req_valid (req_valid),
    .req_div   (req_div),
    .req_ready (req_ready),
    .clk_out   (clk_out),
    .cur_div   (cur_div),
    .busy      (busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic half_tick();
    @(negedge clk);
    #1;
  endtask

  // n posedges; after each, compare clk_out and busy against the MSB-first
  // bit patterns.
  task automatic run_seq(input string tag, input int n,
                         input logic [31:0] clk_exp, input logic [31:0] busy_exp);
    for (int i = 0; i < n; i++) begin
      tick();
      check($sformatf("%s_clk%0d", tag, i), {31'd0, clk_out}, {31'd0, clk_exp[n-1-i]});
      check($sformatf("%s_busy%0d", tag, i), {31'd0, busy}, {31'd0, busy_exp[n-1-i]});
    end
  endtask

  logic [11:0] half_exp;

  initial begin
    rst       = 1'b1;
    en        = 1'b0;
    req_valid = 1'b0;
    req_div   = '0;
    tick();
    tick();

    // Reset state
    check("rst_clk_out",   {31'd0, clk_out},   32'd0);
    check("rst_cur_div",   {24'd0, cur_div},   32'd2);
    check("rst_busy",      {31'd0, busy},      32'd0);
    check("rst_err",       {31'd0, err},       32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_state",     {30'd0, dut.state}, {30'd0, ST_OFF});

    // Start at N=2: first rise on the second posedge after en.
    rst = 1'b0;
    en  = 1'b1;
    tick();                                             // E0
    check("start_state", {30'd0, dut.state}, {30'd0, ST_RUN});
    check("start_clk",   {31'd0, clk_out},   32'd0);
    run_seq("n2", 4, 32'b1010, 32'b0000);               // E1..E4

    // Switch 2 -> 4 (accepted on E5, loaded on E6).
    req_valid = 1'b1;
    req_div   = 8'd4;
    tick();                                             // E5
    req_valid = 1'b0;
    check("sw4_busy",  {31'd0, busy},      32'd1);
    check("sw4_ready", {31'd0, req_ready}, 32'd0);
    tick();                                             // E6
    check("sw4_cur", {24'd0, cur_div}, 32'd4);
    check("sw4_clk", {31'd0, clk_out}, 32'd0);
    run_seq("n4", 4, 32'b1100, 32'b0000);               // E7..E10

    // Switch 4 -> 6 accepted on the edge that takes cnt to 1.
    req_valid = 1'b1;
    req_div   = 8'd6;
    tick();                                             // E11
    req_valid = 1'b0;
    check("sw6_clk",  {31'd0, clk_out}, 32'd1);
    check("sw6_busy", {31'd0, busy},    32'd1);
    // Rest of the N=4 period (busy 3 cycles total), then one N=6 period.
    run_seq("sw6", 10, 32'b10_0111_0001, 32'b11_0000_0000); // E12..E21
    check("sw6_cur", {24'd0, cur_div}, 32'd6);

    // Illegal ratio in RUN: err pulse, no change, no phase disturbance.
    req_valid = 1'b1;
    req_div   = 8'd1;
    tick();                                             // E22
    req_valid = 1'b0;
    check("ill_err",   {31'd0, err},       32'd1);
    check("ill_cur",   {24'd0, cur_div},   32'd6);
    check("ill_state", {30'd0, dut.state}, {30'd0, ST_RUN});
    check("ill_clk",   {31'd0, clk_out},   32'd1);
    tick();                                             // E23
    check("ill_err_end", {31'd0, err},     32'd0);
    check("ill_clk2",    {31'd0, clk_out}, 32'd1);
    run_seq("ill", 4, 32'b0001, 32'b0000);              // E24..E27

    // Switch 6 -> 5.
    req_valid = 1'b1;
    req_div   = 8'd5;
    tick();                                             // E28
    req_valid = 1'b0;
    check("sw5_busy", {31'd0, busy}, 32'd1);
    run_seq("sw5", 4, 32'b1000, 32'b1110);              // E29..E32
    check("sw5_cur", {24'd0, cur_div}, 32'd5);

    // N=5 duty cycle, half-cycle samples from E33 (posedge, negedge, ...).
`ifdef CLK_MODE_CTRL_ODD50_EN
    half_exp = 12'b0111_1100_0001;   // high 2.5 clk, low 2.5 clk
`else
    half_exp = 12'b1111_1100_0011;   // high 3 clk, low 2 clk
`endif
    for (int i = 0; i < 12; i++) begin
      if ((i % 2) == 0) tick();
      else              half_tick();
      check($sformatf("n5_half%0d", i), {31'd0, clk_out}, {31'd0, half_exp[11-i]});
    end

    // Switch 5 -> 8 (accepted on E39, loaded on E42).
    req_valid = 1'b1;
    req_div   = 8'd8;
    tick();                                             // E39
    req_valid = 1'b0;
    check("sw8_busy0", {31'd0, busy}, 32'd1);
    tick();                                             // E40
    tick();                                             // E41
    check("sw8_busy2", {31'd0, busy}, 32'd1);
    tick();                                             // E42
    check("sw8_busy3", {31'd0, busy},    32'd0);
    check("sw8_cur",   {24'd0, cur_div}, 32'd8);
    run_seq("n8", 3, 32'b111, 32'b000);                 // E43..E45

    // Stop mid-period with a legal request in the same cycle.
    en        = 1'b0;
    req_valid = 1'b1;
    req_div   = 8'd3;
    #1;
    check("stop_ready", {31'd0, req_ready}, 32'd0);
    tick();                                             // E46
    req_valid = 1'b0;
    check("stop_state", {30'd0, dut.state}, {30'd0, ST_STOP_PEND});
    check("stop_clk",   {31'd0, clk_out},   32'd1);
    check("stop_busy",  {31'd0, busy},      32'd1);
    check("stop_cur",   {24'd0, cur_div},   32'd8);
    run_seq("stop", 6, 32'b00_0000, 32'b11_1000);       // E47..E52
    check("stop_off",     {30'd0, dut.state}, {30'd0, ST_OFF});
    check("stop_cur_end", {24'd0, cur_div},   32'd8);
    check("stop_ready2",  {31'd0, req_ready}, 32'd1);

    // Restart, request a switch, reset while it is pending.
    en = 1'b1;
    tick();                                             // E53
    tick();                                             // E54
    check("rs_clk", {31'd0, clk_out}, 32'd1);
    req_valid = 1'b1;
    req_div   = 8'd4;
    tick();                                             // E55
    req_valid = 1'b0;
    check("rs_pend", {30'd0, dut.state}, {30'd0, ST_PEND});
    check("rs_clk2", {31'd0, clk_out},   32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rs_clk_low", {31'd0, clk_out},   32'd0);
    check("rs_cur",     {24'd0, cur_div},   32'd2);
    check("rs_state",   {30'd0, dut.state}, {30'd0, ST_OFF});
    check("rs_busy",    {31'd0, busy},      32'd0);
    tick();
    rst = 1'b0;
    en  = 1'b0;
    tick();
    check("rs_after", {31'd0, clk_out}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_clk_mode_ctrl

// File: doc/clk_mode_ctrl.md
CLK_MODE_CTRL -- requirements
Module: clk_mode_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 8, giving the divide-ratio and counter width.
REQ-002 SHALL have parameter DIV_RST, default 2, giving the divide ratio loaded at reset (range 2..2^CNT_W-1).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all flops are clocked by it (posedge, plus the negedge duty flop of REQ-021).
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port en, input, 1 bit: level request to run (1) or stop (0) the divided clock.
REQ-006 SHALL have port req_valid, input, 1 bit: a new divide ratio is offered.
REQ-007 SHALL have port req_div, input, CNT_W bits: the requested divide ratio N.
REQ-008 SHALL have port req_ready, output, 1 bit: the controller accepts req_div this cycle.
REQ-009 SHALL have port clk_out, output, 1 bit: the divided clock.
REQ-010 SHALL have port cur_div, output, CNT_W bits: the divide ratio currently in effect.
REQ-011 SHALL have port busy, output, 1 bit: a ratio switch or stop is pending.
REQ-012 SHALL have port err, output, 1 bit: one-cycle pulse when an illegal ratio is accepted.

Function
REQ-013 SHALL implement FSM states OFF, RUN, PEND (switch pending) and STOP_PEND.
REQ-014 SHALL use a period counter cnt that counts 0..cur_div-1 in RUN, PEND and STOP_PEND, and is held at 0 in OFF.
REQ-015 SHALL register pos_clk <= (cnt < (cur_div+1)>>1) in every state except OFF, where pos_clk <= 0.
REQ-016 SHALL define transitions as follows: OFF->RUN when en=1; RUN->PEND on a legal handshake; RUN->STOP_PEND when en=0; PEND->RUN and STOP_PEND->OFF when cnt==cur_div-1.
REQ-017 SHALL set req_ready = (state==OFF || state==RUN) && !(state==RUN && en==0); a handshake occurs when req_valid && req_ready.
REQ-018 SHALL load a legal request (req_div>=2) into cur_div immediately in OFF; in RUN it is held in a pending register and loaded at the period boundary (cnt==cur_div-1), with cnt going to 0 on the same edge.
REQ-019 SHALL treat req_div<2 as illegal: it is accepted, err pulses for 1 cycle, and state and cur_div are unchanged.
REQ-020 SHALL produce the first clk_out rising edge on the second posedge after en is sampled high; clk_out SHALL never glitch or truncate a high phase at a switch or stop.
REQ-021 SHALL drive clk_out = pos_clk & neg_clk, where neg_clk is the value of pos_clk captured on the negedge; when cur_div is even, neg_clk is forced to 1.
REQ-022 SHALL set busy = (state==PEND || state==STOP_PEND).
REQ-023 SHALL handle en deasserting while in PEND by completing the switch to RUN first, then entering STOP_PEND on the next cycle.

Reset
REQ-024 SHALL, on rst=1 asynchronously: state=OFF, cnt=0, pos_clk=0, neg_clk=0, clk_out=0, cur_div=DIV_RST, pending register=DIV_RST, busy=0, err=0; req_ready then follows REQ-017.
REQ-025 SHALL abort any pending switch or stop on reset mid-operation; clk_out goes low immediately.

Configuration
REQ-026 SHALL, with macro CLK_MODE_CTRL_ODD50_EN defined, include the negedge flop so that odd N gives a 50% duty cycle.
REQ-027 SHALL, without CLK_MODE_CTRL_ODD50_EN, omit the negedge flop and drive clk_out = pos_clk; odd N is then high for (N+1)/2 cycles and low for (N-1)/2 cycles.

Structure
REQ-028 SHALL take the FSM state enum, MIN_DIV=2 and the default CNT_W from shared package clk_mode_pkg.
REQ-029 SHALL place the counter, the pos/neg phase flops and the output AND in sub-module clk_div_core, which has runtime input div and input run; the FSM and handshake stay in clk_mode_ctrl.

Verification
REQ-030 SHALL verify: reset, en=1, DIV_RST=2 -> clk_out period 2 clk, high 1 clk, first rise at the 2nd posedge after en.
REQ-031 SHALL verify: running N=4, request N=6 at cnt=1 -> busy=1 for 3 cycles; the N=4 period completes; the next period is 6 clk with 3 high; cur_div=6.
REQ-032 SHALL verify: N=5 with ODD50_EN -> high 2.5 clk, low 2.5 clk; without ODD50_EN -> high 3 clk, low 2 clk.
REQ-033 SHALL verify: req_div=1 in RUN -> err=1 for 1 cycle; cur_div unchanged; no phase disturbance.
REQ-034 SHALL verify: en=0 mid-period at N=8 -> req_ready=0; the current period finishes; state reaches OFF; clk_out stays 0; a request in the same cycle is not accepted.
REQ-035 SHALL verify: rst pulsed during PEND -> clk_out=0 immediately; cur_div=DIV_RST; state OFF.
